// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor-cluster glue: symbol type and feeder FSM states.
package ltl_mon_pkg;

  localparam int DEFAULT_SYM_W = 8;

  typedef logic [DEFAULT_SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Synchronous symbol FIFO with flush. A push is accepted when full if a pop happens in the same cycle.
// Flush empties the FIFO, and a push in the same cycle becomes the new head.
module ltl_sym_fifo #(
  parameter int SYM_W = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_en   = flush ? push : do_push;
    wr_addr = flush ? '0 : wr_ptr[AW-1:0];
    head    = mem[rd_ptr[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= {{AW{1'b0}}, push};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

endmodule

// File: rtl/ltl_symbol_feeder.sv
// Feeds buffered atomic-proposition symbols to one LTL monitor automaton, framing each trace so
// that the automaton leaves reset in the same cycle symbol 0 is presented.
module ltl_symbol_feeder
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W      = DEFAULT_SYM_W,
  parameter int DEPTH      = 8,
  parameter int ARM_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trace_start,
  input  logic             trace_end,
  input  logic             ap_valid,
  input  logic [SYM_W-1:0] ap_bits,
  output logic             mon_reset,
  output logic             mon_run,
  output logic [SYM_W-1:0] mon_symbols,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] sym_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES - 1);

  feeder_state_e    state, state_nxt;
  logic [ARM_W-1:0] arm_cnt, arm_cnt_nxt;
  logic             end_pend, end_pend_nxt;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [SYM_W-1:0] fifo_head;
  logic             mon_reset_nxt, mon_run_nxt, overflow_nxt;
  logic [SYM_W-1:0] mon_symbols_nxt;
  logic [CNT_W-1:0] sym_count_nxt, drop_count_nxt;
  logic             clear_stats;

  ltl_sym_fifo #(.SYM_W(SYM_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (ap_bits),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    arm_cnt_nxt     = (arm_cnt != '0) ? arm_cnt - 1'b1 : arm_cnt;
    end_pend_nxt    = end_pend;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;
    mon_reset_nxt   = mon_reset;
    mon_run_nxt     = 1'b0;
    mon_symbols_nxt = mon_symbols;
    clear_stats     = 1'b0;

    if (trace_start) begin
      state_nxt     = ARM;
      arm_cnt_nxt   = ARM_LOAD;
      end_pend_nxt  = 1'b0;
      fifo_flush    = 1'b1;
      fifo_push     = ap_valid;
      mon_reset_nxt = 1'b1;
      clear_stats   = 1'b1;
    end else begin
      unique case (state)
        IDLE: mon_reset_nxt = 1'b1;
        ARM: begin
          // A trace_end seen while arming is remembered so the trace drains once streaming starts.
          fifo_push = ap_valid && !end_pend;
          if (trace_end) end_pend_nxt = 1'b1;
          if (arm_cnt == '0 && !fifo_empty) begin
            fifo_pop        = 1'b1;
            mon_reset_nxt   = 1'b0;
            mon_run_nxt     = 1'b1;
            mon_symbols_nxt = fifo_head;
            state_nxt       = (end_pend || trace_end) ? DRAIN : STREAM;
          end else if (trace_end && fifo_empty && !ap_valid) begin
            state_nxt    = IDLE;
            end_pend_nxt = 1'b0;
          end
        end
        STREAM, DRAIN: begin
          fifo_push = ap_valid && (state == STREAM);
          if (!fifo_empty) begin
            fifo_pop        = 1'b1;
            mon_run_nxt     = 1'b1;
            mon_symbols_nxt = fifo_head;
          end
          if (state == STREAM && trace_end) begin
            state_nxt = DRAIN;
          end else if (state == DRAIN && fifo_empty) begin
            state_nxt     = IDLE;
            mon_reset_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    overflow_nxt   = overflow;
    sym_count_nxt  = sym_count;
    drop_count_nxt = drop_count;
    if (clear_stats) begin
      overflow_nxt   = 1'b0;
      sym_count_nxt  = '0;
      drop_count_nxt = '0;
    end else begin
      if (fifo_pop && sym_count != '1) sym_count_nxt = sym_count + 1'b1;
      if (fifo_push && fifo_full && !fifo_pop) begin
        overflow_nxt = 1'b1;
        if (drop_count != '1) drop_count_nxt = drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      arm_cnt     <= '0;
      end_pend    <= 1'b0;
      mon_reset   <= 1'b1;
      mon_run     <= 1'b0;
      mon_symbols <= '0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      sym_count   <= '0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      arm_cnt     <= arm_cnt_nxt;
      end_pend    <= end_pend_nxt;
      mon_reset   <= mon_reset_nxt;
      mon_run     <= mon_run_nxt;
      mon_symbols <= mon_symbols_nxt;
      busy        <= (state_nxt != IDLE);
      overflow    <= overflow_nxt;
      sym_count   <= sym_count_nxt;
      drop_count  <= drop_count_nxt;
    end
  end

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Directed scoreboard bench for ltl_symbol_feeder: a short-arm instance (ARM_CYCLES=2) and a
// long-arm instance (ARM_CYCLES=16, 3-bit counters) that lets the FIFO fill before streaming.
module tb_ltl_symbol_feeder;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic       trace_start, trace_end, ap_valid;
  logic [7:0] ap_bits;

  logic       a_mon_reset, a_mon_run, a_busy, a_overflow;
  logic [7:0] a_mon_symbols;
  logic [31:0] a_sym_count, a_drop_count;
  logic       b_mon_reset, b_mon_run, b_busy, b_overflow;
  logic [7:0] b_mon_symbols;
  logic [2:0] b_sym_count, b_drop_count;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ltl_symbol_feeder #(.SYM_W(8), .DEPTH(8), .ARM_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset_a), .trace_start(trace_start), .trace_end(trace_end),
    .ap_valid(ap_valid), .ap_bits(ap_bits), .mon_reset(a_mon_reset), .mon_run(a_mon_run),
    .mon_symbols(a_mon_symbols), .busy(a_busy), .overflow(a_overflow),
    .sym_count(a_sym_count), .drop_count(a_drop_count)
  );

  ltl_symbol_feeder #(.SYM_W(8), .DEPTH(8), .ARM_CYCLES(16), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset_b), .trace_start(trace_start), .trace_end(trace_end),
    .ap_valid(ap_valid), .ap_bits(ap_bits), .mon_reset(b_mon_reset), .mon_run(b_mon_run),
    .mon_symbols(b_mon_symbols), .busy(b_busy), .overflow(b_overflow),
    .sym_count(b_sym_count), .drop_count(b_drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic en, input logic v, input logic [7:0] bits);
    trace_start = st;
    trace_end   = en;
    ap_valid    = v;
    ap_bits     = bits;
    @(posedge clk);
    #1;
    trace_start = 1'b0;
    trace_end   = 1'b0;
    ap_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_drain(input bit use_b, input int budget);
    int n = 0;
    while (((use_b ? exp_b.size() : exp_a.size()) != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(use_b ? "b_drain_timeout" : "a_drain_timeout",
          use_b ? exp_b.size() : exp_a.size(), 0);
  endtask

  // Scoreboards: every issued symbol must be the next expected one, with the automaton out of reset.
  always @(negedge clk) begin
    if (a_mon_run) begin
      check("a_reset_during_run", {31'd0, a_mon_reset}, 0);
      if (exp_a.size() == 0) check("a_unexpected_issue", {31'd0, a_mon_run}, 0);
      else check("a_symbol", {24'd0, a_mon_symbols}, {24'd0, exp_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (b_mon_run) begin
      check("b_reset_during_run", {31'd0, b_mon_reset}, 0);
      if (exp_b.size() == 0) check("b_unexpected_issue", {31'd0, b_mon_run}, 0);
      else check("b_symbol", {24'd0, b_mon_symbols}, {24'd0, exp_b.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    trace_start = 1'b0; trace_end = 1'b0; ap_valid = 1'b0; ap_bits = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_a = 1'b0;

    check("a_rst_mon_reset", a_mon_reset, 1);
    check("a_rst_mon_run", a_mon_run, 0);
    check("a_rst_symbols", a_mon_symbols, 0);
    check("a_rst_busy", a_busy, 0);
    check("a_rst_overflow", a_overflow, 0);
    check("a_rst_counts", a_sym_count | a_drop_count, 0);

    // Basic framing: reset released with the first symbol.
    exp_a.push_back(8'h21); step(1, 0, 1, 8'h21);
    check("t1_busy", a_busy, 1);
    exp_a.push_back(8'h45); step(0, 0, 1, 8'h45);
    check("t1_arm_reset", a_mon_reset, 1);
    check("t1_arm_run", a_mon_run, 0);
    exp_a.push_back(8'h80); step(0, 0, 1, 8'h80);
    check("t1_first_run", a_mon_run, 1);
    check("t1_first_reset", a_mon_reset, 0);
    check("t1_first_sym", a_mon_symbols, 8'h21);
    wait_drain(0, 10);
    check("t1_sym_count", a_sym_count, 3);

    // Two-cycle latency on an empty FIFO, then symbol holds while run is low.
    exp_a.push_back(8'h5A); step(0, 0, 1, 8'h5A);
    check("lat_t1_run", a_mon_run, 0);
    idle(1);
    check("lat_t2_run", a_mon_run, 1);
    check("lat_t2_sym", a_mon_symbols, 8'h5A);
    idle(1);
    check("hold_run", a_mon_run, 0);
    check("hold_sym", a_mon_symbols, 8'h5A);
    step(0, 1, 0, 8'h00);
    idle(1);
    check("a_end_busy", a_busy, 0);
    check("a_end_mon_reset", a_mon_reset, 1);
    check("a_end_sym_count_held", a_sym_count, 4);

    // Reset mid-stream aborts the trace; ap_valid ignored until trace_start.
    for (int i = 1; i <= 5; i++) begin
      exp_a.push_back(8'(i));
      step(i == 1, 0, 1, 8'(i));
    end
    reset_a = 1'b1;
    step(0, 0, 1, 8'h66);
    reset_a = 1'b0;
    exp_a.delete();
    check("t6_mon_reset", a_mon_reset, 1);
    check("t6_mon_run", a_mon_run, 0);
    check("t6_symbols", a_mon_symbols, 0);
    check("t6_busy", a_busy, 0);
    check("t6_counts", a_sym_count | a_drop_count | {31'd0, a_overflow}, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h70 + 8'(i));
    check("t6_ignore_busy", a_busy, 0);
    check("t6_ignore_count", a_sym_count, 0);
    exp_a.push_back(8'h33); step(1, 0, 1, 8'h33);
    wait_drain(0, 20);
    step(0, 1, 0, 8'h00);
    idle(2);
    check("t6_end_busy", a_busy, 0);

    // Switch to the long-arm instance.
    reset_a = 1'b1;
    reset_b = 1'b0;
    check("b_rst_mon_reset", b_mon_reset, 1);
    check("b_rst_busy", b_busy, 0);

    // Overflow while arming: 12 symbols into 8 entries.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) exp_b.push_back(8'hA0 + 8'(i));
      step(i == 0, 0, 1, 8'hA0 + 8'(i));
    end
    check("t2_overflow", b_overflow, 1);
    check("t2_drop_count", b_drop_count, 4);
    check("t2_arm_reset", b_mon_reset, 1);
    wait_drain(1, 40);
    check("t2_sym_count_sat", b_sym_count, 7);
    step(0, 1, 0, 8'h00);
    idle(2);
    check("t2_end_busy", b_busy, 0);

    // Full FIFO with push and pop together: nothing dropped, order kept.
    for (int i = 0; i < 20; i++) begin
      if (i < 8 || i >= 16) begin
        exp_b.push_back(8'hB0 + 8'(i));
        step(i == 0, 0, 1, 8'hB0 + 8'(i));
      end else begin
        idle(1);
      end
    end
    check("t3_overflow", b_overflow, 0);
    check("t3_drop_count", b_drop_count, 0);
    wait_drain(1, 30);
    check("t3_sym_count_sat", b_sym_count, 7);
    step(0, 1, 0, 8'h00);
    idle(2);

    // trace_end carrying the last symbol with 3 entries queued.
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back(8'hC0 + 8'(i));
      step(i == 0, 0, 1, 8'hC0 + 8'(i));
    end
    idle(13);
    exp_b.push_back(8'hFF); step(0, 1, 1, 8'hFF);
    wait_drain(1, 20);
    idle(2);
    check("t4_busy", b_busy, 0);
    check("t4_mon_reset", b_mon_reset, 1);
    check("t4_mon_run", b_mon_run, 0);
    check("t4_sym_count", b_sym_count, 5);
    check("t4_overflow", b_overflow, 0);

    // Restart mid-stream with 5 queued; trace_start wins over a coincident trace_end.
    for (int i = 0; i < 6; i++) begin
      exp_b.push_back(8'hD0 + 8'(i));
      step(i == 0, 0, 1, 8'hD0 + 8'(i));
    end
    idle(11);
    step(1, 1, 1, 8'h10);
    exp_b.delete();
    exp_b.push_back(8'h10);
    check("t5_mon_reset", b_mon_reset, 1);
    check("t5_mon_run", b_mon_run, 0);
    check("t5_busy", b_busy, 1);
    check("t5_counts", {29'd0, b_sym_count | b_drop_count}, 0);
    check("t5_overflow", b_overflow, 0);
    wait_drain(1, 40);
    check("t5_sym_count", b_sym_count, 1);
    step(0, 1, 0, 8'h00);
    idle(2);
    check("t5_end_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
